// File: rtl/dpram_pkg.sv
// -----------------------------------------------------------------------------
// dpram_pkg
// Shared types and helpers for the parameterised dual-port RAM.
//   rdw_mode_e   : same-port read-during-write behaviour
//   init_state_e : states of the post-reset clear sequencer
//   lane_merge() : byte-lane merge of a new word into an old word
// -----------------------------------------------------------------------------
package dpram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } init_state_e;

  // The merge works on a fixed maximum width so one function serves every
  // instance; callers zero-extend their operands and truncate the result.
  localparam int DPRAM_MAX_W = 256;
  localparam int DPRAM_IDX_W = $clog2(DPRAM_MAX_W);

  // Returns old_word with every lane whose enable bit is set replaced by the
  // corresponding lane of new_word. Lane l covers bits [l*byte_w +: byte_w].
  function automatic logic [DPRAM_MAX_W-1:0] lane_merge(
    input logic [DPRAM_MAX_W-1:0] old_word,
    input logic [DPRAM_MAX_W-1:0] new_word,
    input logic [DPRAM_MAX_W-1:0] lane_we,
    input int                     byte_w
  );
    logic [DPRAM_MAX_W-1:0] res;
    res = old_word;
    for (int b = 0; b < DPRAM_MAX_W; b++) begin
      if (lane_we[DPRAM_IDX_W'(b / byte_w)]) begin
        res[DPRAM_IDX_W'(b)] = new_word[DPRAM_IDX_W'(b)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// -----------------------------------------------------------------------------
// dpram_rd_pipe
// Read-latency pipeline for one RAM port. A word presented with vld_i emerges
// on data_o together with vld_o exactly RD_LAT cycles later. Each data stage
// loads only when its valid is set, so data_o holds its last value between
// valid pulses. Synchronous active-low reset flushes every stage to zero.
//   clk_i   : clock
//   rst_ni  : synchronous reset, active low
//   vld_i   : request accepted this cycle
//   data_i  : word read this cycle
//   vld_o   : data_o carries a new word this cycle
//   data_o  : read data
// -----------------------------------------------------------------------------
module dpram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic              s1_vld_q;
  logic [DATA_W-1:0] s1_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= vld_i;
      if (vld_i) begin
        s1_data_q <= data_i;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_vld_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        s2_vld_q  <= 1'b0;
        s2_data_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign vld_o  = s2_vld_q;
    assign data_o = s2_data_q;
  end else begin : g_lat1
    assign vld_o  = s1_vld_q;
    assign data_o = s1_data_q;
  end

endmodule

// File: rtl/param_dual_port_ram.sv
// -----------------------------------------------------------------------------
// param_dual_port_ram
// True dual-port RAM with byte-lane write enables, configurable read latency,
// selectable same-port read-during-write behaviour, same-address collision
// flag and an optional zero-fill sequence after reset.
//
//   clk                 : single clock, rising edge
//   rst_n               : synchronous reset, active low
//   en_a / en_b         : request valid
//   we_a / we_b         : byte-lane write enables (NB bits)
//   addr_a / addr_b     : word address
//   data_in_a/_b        : write data
//   data_out_a/_b       : read data, held while valid is low
//   valid_a / valid_b   : read data valid, RD_LAT cycles after acceptance
//   collision           : one-cycle pulse after a same-address write conflict
//   init_busy           : zero-fill in progress, requests are dropped
//
// Init FSM
//   state | meaning
//   IDLE  | in / just out of reset, decide whether to zero-fill
//   CLEAR | writing zero to clr_addr_q, one word per cycle
//   READY | normal operation, requests accepted
// -----------------------------------------------------------------------------
module param_dual_port_ram
  import dpram_pkg::*;
#(
  parameter int        DATA_W        = 32,
  parameter int        BYTE_W        = 8,
  parameter int        ADDR_W        = 6,
  parameter int        RD_LAT        = 1,
  parameter rdw_mode_e RDW_MODE      = READ_FIRST,
  parameter bit        INIT_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_a,
  input  logic [DATA_W/BYTE_W-1:0] we_a,
  input  logic [ADDR_W-1:0]        addr_a,
  input  logic [DATA_W-1:0]        data_in_a,
  output logic [DATA_W-1:0]        data_out_a,
  output logic                     valid_a,
  input  logic                     en_b,
  input  logic [DATA_W/BYTE_W-1:0] we_b,
  input  logic [ADDR_W-1:0]        addr_b,
  input  logic [DATA_W-1:0]        data_in_b,
  output logic [DATA_W-1:0]        data_out_b,
  output logic                     valid_b,
  output logic                     collision,
  output logic                     init_busy
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("param_dual_port_ram: RD_LAT must be 1 or 2");
  end
  if (BYTE_W < 1 || (DATA_W % BYTE_W) != 0) begin : g_bad_byte_w
    $error("param_dual_port_ram: DATA_W must be a multiple of BYTE_W");
  end
  if (DATA_W > DPRAM_MAX_W) begin : g_bad_data_w
    $error("param_dual_port_ram: DATA_W exceeds lane_merge width");
  end

  function automatic logic [DATA_W-1:0] merge_w(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NB-1:0]     lane_we
  );
    return DATA_W'(lane_merge(DPRAM_MAX_W'(old_word), DPRAM_MAX_W'(new_word),
                              DPRAM_MAX_W'(lane_we), BYTE_W));
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  init_state_e       state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              init_busy_q;
  logic              collision_q;

  logic              acc_a, acc_b;
  logic              wr_a, wr_b;
  logic              same_addr;
  logic              clr_we;
  logic [DATA_W-1:0] old_a, old_b;
  logic [DATA_W-1:0] own_a, own_b;
  logic [DATA_W-1:0] wr_word_a;
  logic [DATA_W-1:0] rd_word_a, rd_word_b;

  // Requests are ignored while filling and on any edge where reset is low, so
  // a request coinciding with reset assertion cannot write.
  assign acc_a     = rst_n & en_a & ~init_busy_q;
  assign acc_b     = rst_n & en_b & ~init_busy_q;
  assign wr_a      = acc_a & (|we_a);
  assign wr_b      = acc_b & (|we_b);
  assign same_addr = (addr_a == addr_b);
  assign clr_we    = rst_n & (state_q == CLEAR);

  assign old_a = mem_q[addr_a];
  assign old_b = mem_q[addr_b];
  assign own_a = merge_w(old_a, data_in_a, we_a);
  assign own_b = merge_w(old_b, data_in_b, we_b);

  // On a same-address double write, A's word is built on top of B's merge:
  // B's lanes survive where A is disabled, A wins where both are enabled.
  assign wr_word_a = (wr_b && same_addr) ? merge_w(own_b, data_in_a, we_a) : own_a;

  // The other port's write is never visible to a read in the same cycle.
  assign rd_word_a = (RDW_MODE == WRITE_FIRST) ? own_a : old_a;
  assign rd_word_b = (RDW_MODE == WRITE_FIRST) ? own_b : old_b;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr_q] <= '0;
    end else begin
      if (wr_b) begin
        mem_q[addr_b] <= own_b;
      end
      if (wr_a) begin
        mem_q[addr_a] <= wr_word_a;
      end
    end
  end

  // init_busy_q is registered alongside the state and equals (state != READY).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clr_addr_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clr_addr_q <= '0;
          if (INIT_ON_RESET) begin
            state_q <= CLEAR;
          end else begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_addr_q == '1) begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        READY: begin
          init_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          init_busy_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= acc_a & acc_b & same_addr & ((|we_a) | (|we_b));
    end
  end

  dpram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vld_i  (acc_a),
    .data_i (rd_word_a),
    .vld_o  (valid_a),
    .data_o (data_out_a)
  );

  dpram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vld_i  (acc_b),
    .data_i (rd_word_b),
    .vld_o  (valid_b),
    .data_o (data_out_b)
  );

  assign collision = collision_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_param_dual_port_ram.sv
// -----------------------------------------------------------------------------
// tb_param_dual_port_ram
// Two instances share one stimulus stream: u_dut1 uses the defaults
// (RD_LAT=1, READ_FIRST) and u_dut2 uses RD_LAT=2, WRITE_FIRST.
// -----------------------------------------------------------------------------
module tb_param_dual_port_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [31:0] dout_a1, dout_b1, dout_a2, dout_b2;
  logic        vld_a1, vld_b1, vld_a2, vld_b2;
  logic        col1, col2, busy1, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_dual_port_ram u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_a       (en_a),
    .we_a       (we_a),
    .addr_a     (addr_a),
    .data_in_a  (din_a),
    .data_out_a (dout_a1),
    .valid_a    (vld_a1),
    .en_b       (en_b),
    .we_b       (we_b),
    .addr_b     (addr_b),
    .data_in_b  (din_b),
    .data_out_b (dout_b1),
    .valid_b    (vld_b1),
    .collision  (col1),
    .init_busy  (busy1)
  );

  param_dual_port_ram #(
    .RD_LAT   (2),
    .RDW_MODE (dpram_pkg::WRITE_FIRST)
  ) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_a       (en_a),
    .we_a       (we_a),
    .addr_a     (addr_a),
    .data_in_a  (din_a),
    .data_out_a (dout_a2),
    .valid_a    (vld_a2),
    .en_b       (en_b),
    .we_b       (we_b),
    .addr_b     (addr_b),
    .data_in_b  (din_b),
    .data_out_b (dout_b2),
    .valid_b    (vld_b2),
    .collision  (col2),
    .init_busy  (busy2)
  );

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0;
    en_b = 1'b0;
    we_a = 4'h0;
    we_b = 4'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int bad;
    int leak;
    logic exp_v;

    rst_n  = 1'b0;
    idle();
    addr_a = '0;
    addr_b = '0;
    din_a  = '0;
    din_b  = '0;
    tick(); tick(); tick();

    // reset state
    chk_w("rst_dout_a1", dout_a1, 32'h0);
    chk_w("rst_dout_b2", dout_b2, 32'h0);
    chk_b("rst_vld_a1", vld_a1, 1'b0);
    chk_b("rst_vld_b2", vld_b2, 1'b0);
    chk_b("rst_col1", col1, 1'b0);
    chk_b("rst_busy1", busy1, 1'b1);

    // zero-fill after release
    rst_n    = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (busy1) busy_cnt++;
      else break;
    end
    chk_i("clr_busy_cycles", busy_cnt, 64);
    chk_b("clr_busy2_done", busy2, 1'b0);

    bad = 0;
    for (int i = 0; i < 64; i++) begin
      en_a   = 1'b1;
      addr_a = 6'(i);
      tick();
      if (!vld_a1 || dout_a1 !== 32'h0) bad++;
      if (i > 0 && (!vld_a2 || dout_a2 !== 32'h0)) bad++;
    end
    idle();
    tick();
    if (!vld_a2 || dout_a2 !== 32'h0) bad++;
    chk_i("clr_all_zero", bad, 0);
    chk_b("clr_rd_vld_off", vld_a1, 1'b0);

    // A writes addr 5, B reads it next cycle
    en_a = 1'b1; we_a = 4'hF; addr_a = 6'd5; din_a = 32'hDEADBEEF;
    tick();
    chk_b("wr5_vld_a1", vld_a1, 1'b1);
    chk_w("wr5_rdfirst_a1", dout_a1, 32'h0);
    chk_b("wr5_vld_a2_lat", vld_a2, 1'b0);
    idle(); en_b = 1'b1; addr_b = 6'd5;
    tick();
    chk_b("rd5_vld_b1", vld_b1, 1'b1);
    chk_w("rd5_data_b1", dout_b1, 32'hDEADBEEF);
    chk_w("wr5_wrfirst_a2", dout_a2, 32'hDEADBEEF);
    idle();
    tick();
    chk_b("rd5_vld_b1_off", vld_b1, 1'b0);
    chk_w("rd5_hold_b1", dout_b1, 32'hDEADBEEF);
    chk_b("rd5_vld_b2", vld_b2, 1'b1);
    chk_w("rd5_data_b2", dout_b2, 32'hDEADBEEF);

    // same-port read-during-write with partial lanes
    en_a = 1'b1; we_a = 4'hF; addr_a = 6'd3; din_a = 32'h11111111;
    tick();
    we_a = 4'b0011; din_a = 32'hAABBCCDD;
    tick();
    chk_w("rdw_rdfirst", dout_a1, 32'h11111111);
    idle();
    tick();
    chk_w("rdw_wrfirst", dout_a2, 32'h1111CCDD);
    en_b = 1'b1; addr_b = 6'd3;
    tick();
    chk_w("rdw_mem_b1", dout_b1, 32'h1111CCDD);
    idle();
    tick();
    chk_w("rdw_mem_b2", dout_b2, 32'h1111CCDD);

    // cross-port read of an address being written
    en_a = 1'b1; we_a = 4'hF; addr_a = 6'd7; din_a = 32'h12345678;
    en_b = 1'b1; we_b = 4'h0; addr_b = 6'd7;
    tick();
    chk_w("xrd_b1", dout_b1, 32'h0);
    chk_b("xrd_col1", col1, 1'b1);
    idle();
    tick();
    chk_b("xrd_vld_b2", vld_b2, 1'b1);
    chk_w("xrd_b2", dout_b2, 32'h0);
    chk_b("xrd_col_one_cycle", col1, 1'b0);

    // both ports write addr 9
    en_a = 1'b1; we_a = 4'hF; addr_a = 6'd9; din_a = 32'h000000EE;
    tick();
    we_a = 4'b1100; din_a = 32'hAAAAAAAA;
    en_b = 1'b1; we_b = 4'b0110; addr_b = 6'd9; din_b = 32'hBBBBBBBB;
    tick();
    chk_b("ww_col1", col1, 1'b1);
    chk_b("ww_col2", col2, 1'b1);
    idle(); en_a = 1'b1; en_b = 1'b1;
    tick();
    chk_b("ww_col_once", col1, 1'b0);
    chk_w("ww_merge_a1", dout_a1, 32'hAAAABBEE);
    chk_w("ww_merge_b1", dout_b1, 32'hAAAABBEE);
    idle();
    tick();
    chk_b("rr_no_col", col1, 1'b0);
    chk_w("ww_merge_a2", dout_a2, 32'hAAAABBEE);

    // port B writes, read back through A
    en_b = 1'b1; we_b = 4'hF; addr_b = 6'd40; din_b = 32'h40404040;
    tick();
    addr_b = 6'd63; din_b = 32'h63636363;
    tick();
    idle(); en_a = 1'b1; addr_a = 6'd63;
    tick();
    chk_w("b_write63", dout_a1, 32'h63636363);
    idle();

    // reset in the middle of the fill, at clear address 20
    rst_n = 1'b0;
    tick(); tick();
    chk_w("mid_rst_dout_a1", dout_a1, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 21; k++) tick();
    rst_n = 1'b0;
    tick();
    chk_b("midclr_busy", busy1, 1'b1);
    rst_n = 1'b1;
    en_a = 1'b1; we_a = 4'hF; addr_a = 6'd50; din_a = 32'h55555555;
    en_b = 1'b1; addr_b = 6'd40;
    busy_cnt = 0;
    leak     = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (vld_a1 || vld_b1 || vld_a2 || vld_b2 || col1 || col2) leak++;
      if (busy1) busy_cnt++;
      else break;
    end
    idle();
    chk_i("reclr_busy_cycles", busy_cnt, 64);
    chk_i("reclr_no_valid", leak, 0);
    en_a = 1'b1; addr_a = 6'd40;
    tick();
    chk_w("reclr_40", dout_a1, 32'h0);
    addr_a = 6'd63;
    tick();
    chk_w("reclr_63", dout_a1, 32'h0);
    addr_a = 6'd50;
    tick();
    chk_w("reclr_50_dropped", dout_a1, 32'h0);
    idle();
    tick();

    // back-to-back reads on B of addr 0..7
    for (int i = 0; i < 8; i++) begin
      en_a = 1'b1; we_a = 4'hF; addr_a = 6'(i); din_a = 32'hC0DE0000 + 32'(i);
      tick();
    end
    idle();
    tick();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      en_b   = (c < 8);
      addr_b = 6'(c);
      tick();
      exp_v = (c >= 1 && c <= 8);
      chk_b("b2b_vld2", vld_b2, exp_v);
      if (exp_v) chk_w("b2b_data2", dout_b2, 32'hC0DE0000 + 32'(c - 1));
      if (vld_b1 !== (c < 8)) bad++;
    end
    idle();
    chk_i("b2b_vld1_pattern", bad, 0);
    chk_w("b2b_hold2", dout_b2, 32'hC0DE0007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
